// File: rtl/fifo_rd_checker_pkg.sv
// Shared types and constants for the FIFO read-side checker.
// Holds the burst FSM encoding and the stall LFSR seed/taps.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    WAIT  = 2'd2
  } rd_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/fifo_rd_checker_if.sv
// Read-side FIFO handshake bundle: master is the reader, slave is the FIFO.
// rd_en is the only reader-driven signal; everything else comes from the FIFO.
interface fifo_rd_checker_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 10
);
  logic              rd_en;
  logic              empty;
  logic              valid;
  logic [DATA_W-1:0] dout;
  logic [CNT_W-1:0]  rd_data_count;

  modport master (output rd_en, input empty, valid, dout, rd_data_count);
  modport slave  (input rd_en, output empty, valid, dout, rd_data_count);
endinterface

// File: rtl/fifo_rd_checker_lfsr16.sv
// 16-bit Fibonacci LFSR used to generate pseudo-random read stalls.
// Latency: state advances one step per enabled cycle, seeded on reset.
// Backpressure: none, free-running.
module lfsr16
  import fifo_rd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LFSR_SEED;
    end else if (en) begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/fifo_rd_checker.sv
// Drains a FIFO in threshold-triggered bursts and checks for an incrementing data stream.
// Latency: rd_en is combinational from state/empty; counters update on the edge sampling valid.
// Backpressure: honours empty same-cycle; FIFO_RD_STALL_EN adds pseudo-random read stalls.
module fifo_rd_checker
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 10,
  parameter int THRESH    = 4,
  parameter int BURST_LEN = 8,
  parameter int ERRCNT_W  = 16
) (
  input  logic                rd_clk,
  input  logic                reset,
  input  logic                enable,
  fifo_rd_checker_if.master   fifo,
  output logic                busy,
  output logic                locked,
  output logic [31:0]         word_count,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [DATA_W-1:0]   last_err_exp,
  output logic [DATA_W-1:0]   last_err_got
);

  localparam int ISS_W = $clog2(BURST_LEN + 1);

  rd_state_t         state;
  logic [ISS_W-1:0]  issued;
  logic [ISS_W-1:0]  outstanding;
  logic [DATA_W-1:0] expected;
  logic              stall;

`ifdef FIFO_RD_STALL_EN
  logic [15:0] lfsr;

  lfsr16 u_lfsr (
    .clk   (rd_clk),
    .reset (reset),
    .en    (1'b1),
    .state (lfsr)
  );

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign busy       = (state != IDLE);
  assign fifo.rd_en = (state == BURST) && !fifo.empty && !stall &&
                      (issued < ISS_W'(BURST_LEN));

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state       <= IDLE;
      issued      <= '0;
      outstanding <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && (fifo.rd_data_count >= CNT_W'(THRESH))) begin
            state  <= BURST;
            issued <= '0;
          end
        end
        BURST: begin
          if (fifo.rd_en) begin
            issued <= issued + 1'b1;
          end
          // Stalls keep the burst open; only the length cap or a drained FIFO closes it
          if (fifo.rd_en && (issued == ISS_W'(BURST_LEN - 1))) begin
            state <= WAIT;
          end else if (fifo.empty && (issued != '0)) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (outstanding == '0) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (fifo.rd_en && !fifo.valid) begin
        outstanding <= outstanding + 1'b1;
      end else if (!fifo.rd_en && fifo.valid && (outstanding != '0)) begin
        outstanding <= outstanding - 1'b1;
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      locked       <= 1'b0;
      expected     <= '0;
      word_count   <= '0;
      err_count    <= '0;
      last_err_exp <= '0;
      last_err_got <= '0;
    end else if (fifo.valid) begin
      word_count <= word_count + 32'd1;
      locked     <= 1'b1;
      // Seed, match and resync all move expected to the word after the one received
      expected   <= fifo.dout + 1'b1;
      if (locked && (fifo.dout != expected)) begin
        if (err_count != '1) begin
          err_count <= err_count + 1'b1;
        end
        last_err_exp <= expected;
        last_err_got <= fifo.dout;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Directed bench for fifo_rd_checker with a behavioural 1-cycle-latency FIFO model.
// Each step drives a short stream and compares against hand-computed values.
module tb_fifo_rd_checker;

  logic        rd_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        flush;
  logic        wr_req;
  logic [15:0] wr_val;
  logic        busy;
  logic        locked;
  logic [31:0] word_count;
  logic [15:0] err_count;
  logic [15:0] last_err_exp;
  logic [15:0] last_err_got;

  logic [15:0] mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        vld_q  = 1'b0;
  logic [15:0] dout_q = 16'h0;

  int n_chk    = 0;
  int n_pass   = 0;
  int rd_seen  = 0;
  int vld_seen = 0;
  int illegal  = 0;
  int rd_base;
  int vld_base;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_checker_if #(.DATA_W(16), .CNT_W(10)) bus ();

  fifo_rd_checker #(
    .DATA_W    (16),
    .CNT_W     (10),
    .THRESH    (4),
    .BURST_LEN (8),
    .ERRCNT_W  (16)
  ) dut (
    .rd_clk       (rd_clk),
    .reset        (reset),
    .enable       (enable),
    .fifo         (bus),
    .busy         (busy),
    .locked       (locked),
    .word_count   (word_count),
    .err_count    (err_count),
    .last_err_exp (last_err_exp),
    .last_err_got (last_err_got)
  );

  assign bus.valid         = vld_q;
  assign bus.dout          = dout_q;
  assign bus.empty         = (wr_ptr == rd_ptr);
  assign bus.rd_data_count = 10'(wr_ptr - rd_ptr);

  // FIFO model: one write port, read data returned one cycle after rd_en
  always @(posedge rd_clk) begin
    if (flush) begin
      wr_ptr <= 0;
      rd_ptr <= 0;
      vld_q  <= 1'b0;
    end else begin
      if (wr_req) begin
        mem[wr_ptr[7:0]] <= wr_val;
        wr_ptr           <= wr_ptr + 1;
      end
      if (bus.rd_en && !bus.empty) begin
        dout_q <= mem[rd_ptr[7:0]];
        rd_ptr <= rd_ptr + 1;
        vld_q  <= 1'b1;
      end else begin
        vld_q <= 1'b0;
      end
    end
  end

  always @(negedge rd_clk) begin
    if (bus.rd_en) rd_seen++;
    if (bus.valid) vld_seen++;
    if (bus.rd_en && bus.empty) illegal++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge rd_clk);
      if (busy === lvl) break;
    end
    n_chk++;
    assert (busy === lvl) n_pass++;
    else $error("FAIL %s (timeout): observed busy=%0b, expected %0b", tag, busy, lvl);
  endtask

  task automatic push(input logic [15:0] v);
    @(negedge rd_clk);
    wr_req = 1'b1;
    wr_val = v;
  endtask

  task automatic push_done();
    @(negedge rd_clk);
    wr_req = 1'b0;
  endtask

  task automatic run_burst(input string tag);
    enable = 1'b1;
    wait_busy(1'b1, tag);
    enable = 1'b0;
    wait_busy(1'b0, tag);
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    reset  = 1'b1;
    flush  = 1'b1;
    enable = 1'b0;
    @(negedge rd_clk);
    @(negedge rd_clk);
    reset = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    flush  = 1'b1;
    enable = 1'b0;
    wr_req = 1'b0;
    wr_val = 16'h0;
    repeat (3) @(negedge rd_clk);

    chk("rst_rd_en", {31'd0, bus.rd_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_word_count", word_count, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    chk("rst_last_exp", {16'd0, last_err_exp}, 32'd0);
    chk("rst_last_got", {16'd0, last_err_got}, 32'd0);
    reset = 1'b0;
    flush = 1'b0;

    // Continuous writer 0..11; burst must start once four words are queued
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge rd_clk);
      if (k == 4) chk("burst_not_yet", {31'd0, busy}, 32'd0);
      if (k == 5) begin
        chk("burst_start", {31'd0, busy}, 32'd1);
        enable = 1'b0;
      end
      wr_req = 1'b1;
      wr_val = 16'(k);
    end
    @(negedge rd_clk);
    wr_req = 1'b0;
    wait_busy(1'b0, "first_burst_done");
    chk("seq_word_count", word_count, 32'd8);
    chk("seq_err_count", {16'd0, err_count}, 32'd0);
    chk("seq_locked", {31'd0, locked}, 32'd1);
    repeat (3) @(negedge rd_clk);
    chk("no_burst_when_disabled", {31'd0, busy}, 32'd0);
    run_burst("second_burst");
    chk("seq2_word_count", word_count, 32'd12);
    chk("seq2_err_count", {16'd0, err_count}, 32'd0);

    // Gap in the sequence: 5,6,8,9 then resynced continuation 10..13
    do_reset();
    push(16'd5); push(16'd6); push(16'd8); push(16'd9);
    push_done();
    run_burst("gap_burst");
    chk("gap_err_count", {16'd0, err_count}, 32'd1);
    chk("gap_last_exp", {16'd0, last_err_exp}, 32'd7);
    chk("gap_last_got", {16'd0, last_err_got}, 32'd8);
    chk("gap_word_count", word_count, 32'd4);
    for (int v = 10; v < 14; v++) push(16'(v));
    push_done();
    run_burst("resync_burst");
    chk("resync_err_count", {16'd0, err_count}, 32'd1);
    chk("resync_word_count", word_count, 32'd8);
    chk("resync_last_got", {16'd0, last_err_got}, 32'd8);

    // Wrap through 0xFFFF -> 0x0000
    do_reset();
    push(16'hFFFE); push(16'hFFFF); push(16'h0000); push(16'h0001);
    push_done();
    run_burst("wrap_burst");
    chk("wrap_err_count", {16'd0, err_count}, 32'd0);
    chk("wrap_word_count", word_count, 32'd4);
    chk("wrap_locked", {31'd0, locked}, 32'd1);

    // Exactly five words: burst ends on empty, not on length
    do_reset();
    rd_base  = rd_seen;
    vld_base = vld_seen;
    for (int v = 20; v < 25; v++) push(16'(v));
    push_done();
    run_burst("five_burst");
    chk("five_reads", 32'(rd_seen - rd_base), 32'd5);
    chk("five_valids", 32'(vld_seen - vld_base), 32'd5);
    chk("five_word_count", word_count, 32'd5);
    chk("five_err_count", {16'd0, err_count}, 32'd0);

    // Reset pulsed mid-burst, then the writer restarts at 100
    do_reset();
    for (int v = 50; v < 58; v++) push(16'(v));
    push_done();
    enable = 1'b1;
    wait_busy(1'b1, "mid_burst_start");
    enable = 1'b0;
    repeat (3) @(negedge rd_clk);
    chk("mid_rd_en", {31'd0, bus.rd_en}, 32'd1);
    chk("mid_word_count", word_count, 32'd2);
    reset = 1'b1;
    @(negedge rd_clk);
    chk("mid_rst_rd_en", {31'd0, bus.rd_en}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_word_count", word_count, 32'd0);
    chk("mid_rst_locked", {31'd0, locked}, 32'd0);
    flush = 1'b1;
    @(negedge rd_clk);
    reset = 1'b0;
    flush = 1'b0;
    for (int v = 100; v < 104; v++) push(16'(v));
    push_done();
    run_burst("reseed_burst");
    chk("reseed_word_count", word_count, 32'd4);
    chk("reseed_err_count", {16'd0, err_count}, 32'd0);
    chk("reseed_locked", {31'd0, locked}, 32'd1);

    chk("rd_en_while_empty", 32'(illegal), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
